alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Accepts decoded-register operands plus the raw instruction over a valid/ready handshake, and decodes opcode/funct into the 3-bit ALUSRC code.
- Resolves forwarding from EX and MEM, detects load-use hazards and inserts bubbles.
- Drives registered A/B/C/ALUSRC into the ALU together with the EX control bits.

Parameters:
- ANN_OPCODE, 6'h1C, custom opcode for ANN ops; funct 6'h00 = ANN evaluate, funct 6'h01 = weight load.

Ports:
- clk  in  1  clock (all state updates on posedge)
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  MIPS instruction word
- in_rs_val  in  32  register-file value of rs
- in_rt_val  in  32  register-file value of rt
- ex_y  in  32  ALU result of the instruction currently held in this stage
- mem_rd  in  5  destination register of the instruction in MEM
- mem_regwrite  in  1  MEM instruction writes a register
- mem_data  in  32  value MEM will write back (load data or ALU result)
- flush  in  1  kill the held instruction and the incoming one
- out_ready  in  1  downstream (EX/MEM) can advance
- out_valid  out  1  A/B/C/ALUSRC hold a real instruction
- A  out  32  ALU operand A
- B  out  32  ALU operand B
- C  out  32  ALU operand C (weight-load third value)
- ALUSRC  out  3  ALU operation code
- out_rd  out  5  destination register
- out_regwrite, out_memread, out_memwrite, out_illegal  out  1 each  control bits for later stages

Behaviour:
- Reset: out_valid=0, A=B=C=0, ALUSRC=000, out_rd=0, all control outputs 0; in_ready=0 during the reset cycle.
- ALUSRC codes:
  - 000 add; 001 sub; 011 or; 100 ANN evaluate; 101 weight load; 010 and (default).
  - ALUSRC=101 only while out_valid=1. Any bubble or invalid slot forces ALUSRC=000, so the ALU never reloads weights spuriously.
- Decode, R-type (opcode 0):
  - funct 20/21 → 000; funct 22/23 → 001; funct 24 → 010; funct 25 → 011.
  - rd = instr[15:11], regwrite=1.
- Decode, I-type:
  - addi/addiu (08/09) → 000, B = sign-extended imm.
  - andi (0C) → 010, B = zero-extended imm; ori (0D) → 011, B = zero-extended imm.
  - lw (23) → 000, sign-extended imm, memread=1.
  - sw (2B) → 000, sign-extended imm, memwrite=1, regwrite=0.
  - beq (04) → 001, B = rt, regwrite=0.
  - For addi/addiu/andi/ori/lw, rd = instr[20:16].
- Decode, ANN ops:
  - ANN_OPCODE funct 00 → 100, A=rs, B=rt, rd=instr[15:11], regwrite=1.
  - ANN_OPCODE funct 01 → 101, A=rs, B=rt, C=rd-field register value, supplied on in_rt_val by upstream; regwrite=0.
  - C=0 for every op other than weight load.
- Illegal encodings: out_illegal=1, ALUSRC=010, regwrite=memread=memwrite=0, out_valid=1.
- Forwarding, per source operand (rs, rt) when its index ≠ 0:
  - Priority 1: held instr valid && regwrite && !memread && out_rd == index → ex_y.
  - Priority 2: mem_regwrite && mem_rd == index → mem_data.
  - Otherwise the register-file value.
  - Register 0 is never forwarded.
- Load-use hazard: held instr valid && memread && out_rd ≠ 0 && out_rd equals an operand the incoming instr reads.
  - Response: in_ready=0; if out_ready=1, next edge loads a bubble (out_valid=0).
  - The instruction is accepted the following cycle, forwarded from MEM.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Advance rules:
  - Transfer on in_valid && in_ready → registers load the decoded instruction, out_valid=1.
  - out_ready=1 with no transfer → out_valid=0.
  - out_ready=0 → all outputs held unchanged (a held weight load repeats 101 with identical values, which is benign).
- Flush (priority over everything except rst): next edge out_valid=0, ALUSRC=000; the incoming instruction is dropped.
- Latency: one cycle from accept to ALU inputs. Throughput: 1 instr/cycle without hazards.
- A weight load followed immediately by an ANN evaluate is legal; the ALU updates its weights on the edge where the evaluate enters.

Decomposition:
- Shared package alu_pkg:
  - ALUSRC code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_ANN, ALU_WLOAD).
  - Opcode and funct constants; ANN funct codes.
- One combinational sub-module, alu_decode: instr → ALUSRC, imm select/extension, rd, control bits, uses_rs/uses_rt, illegal.
- Forwarding, hazard, handshake and pipeline register stay in alu_issue_stage.

Test Plan:
- Reset, then R-type add $3,$1,$2 with rs=5, rt=7 → next cycle out_valid=1, ALUSRC=000, A=5, B=7, out_rd=3, out_regwrite=1.
- addi $4,$3,-1 directly after add $3 with ex_y=12 → A=12 (EX forward), B=32'hFFFFFFFF; ori with imm 16'h8000 → B=32'h00008000.
- lw $5,0($1) then add $6,$5,$5 → in_ready=0 one cycle, a bubble with ALUSRC=000 and out_valid=0, then add accepted with A=B=mem_data=32'hDEAD.
- Weight load (ANN funct 01) with rs=1, rt=2, C=3, followed by ANN evaluate → ALUSRC sequence 101 then 100; out_ready=0 for 2 cycles holds 101 and A/B/C unchanged.
- flush asserted while an ANN evaluate is held and a new add is on the input → next cycle out_valid=0, ALUSRC=000, add not accepted (in_ready=0).
- Illegal opcode 6'h3F → out_illegal=1, ALUSRC=010, out_regwrite=0; a forward target of $0 always yields the register-file value 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALUSRC codes, MIPS opcodes/functs and ANN op codes.
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_ANN   = 3'b100;
    localparam logic [2:0] ALU_WLOAD = 3'b101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ANN   = 6'h1C;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;

    localparam logic [5:0] ANN_F_EVAL  = 6'h00;
    localparam logic [5:0] ANN_F_WLOAD = 6'h01;

    typedef enum logic [1:0] {ImmNone, ImmSext, ImmZext} imm_sel_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder: instruction word to ALUSRC, immediate select, destination and control bits.
module alu_decode
    import alu_pkg::*;
#(
    parameter logic [5:0] ANN_OPCODE = OP_ANN
) (
    input  logic [31:0] instr_i,
    output logic [2:0]  alusrc_o,
    output imm_sel_e    imm_sel_o,
    output logic [4:0]  rd_o,
    output logic        regwrite_o,
    output logic        memread_o,
    output logic        memwrite_o,
    output logic        uses_rs_o,
    output logic        uses_rt_o,
    output logic        wload_o,
    output logic        illegal_o
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        alusrc_o   = ALU_AND;
        imm_sel_o  = ImmNone;
        rd_o       = 5'd0;
        regwrite_o = 1'b0;
        memread_o  = 1'b0;
        memwrite_o = 1'b0;
        uses_rs_o  = 1'b0;
        uses_rt_o  = 1'b0;
        wload_o    = 1'b0;
        illegal_o  = 1'b0;
        if (opcode == OP_RTYPE) begin
            uses_rs_o  = 1'b1;
            uses_rt_o  = 1'b1;
            rd_o       = instr_i[15:11];
            regwrite_o = 1'b1;
            case (funct)
                F_ADD, F_ADDU: alusrc_o = ALU_ADD;
                F_SUB, F_SUBU: alusrc_o = ALU_SUB;
                F_AND:         alusrc_o = ALU_AND;
                F_OR:          alusrc_o = ALU_OR;
                default:       illegal_o = 1'b1;
            endcase
        end else if (opcode == ANN_OPCODE) begin
            uses_rs_o = 1'b1;
            uses_rt_o = 1'b1;
            if (funct == ANN_F_EVAL) begin
                alusrc_o   = ALU_ANN;
                rd_o       = instr_i[15:11];
                regwrite_o = 1'b1;
            end else if (funct == ANN_F_WLOAD) begin
                alusrc_o = ALU_WLOAD;
                wload_o  = 1'b1;
            end else begin
                illegal_o = 1'b1;
            end
        end else begin
            case (opcode)
                OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LW: begin
                    uses_rs_o  = 1'b1;
                    rd_o       = instr_i[20:16];
                    regwrite_o = 1'b1;
                    imm_sel_o  = ImmSext;
                    alusrc_o   = ALU_ADD;
                    if (opcode == OP_ANDI) begin
                        alusrc_o  = ALU_AND;
                        imm_sel_o = ImmZext;
                    end else if (opcode == OP_ORI) begin
                        alusrc_o  = ALU_OR;
                        imm_sel_o = ImmZext;
                    end
                    memread_o = (opcode == OP_LW);
                end
                // Store data travels on rt, so it still counts as a read for hazards.
                OP_SW: begin
                    uses_rs_o  = 1'b1;
                    uses_rt_o  = 1'b1;
                    imm_sel_o  = ImmSext;
                    alusrc_o   = ALU_ADD;
                    memwrite_o = 1'b1;
                end
                OP_BEQ: begin
                    uses_rs_o = 1'b1;
                    uses_rt_o = 1'b1;
                    alusrc_o  = ALU_SUB;
                end
                default: illegal_o = 1'b1;
            endcase
        end
        if (illegal_o) begin
            alusrc_o   = ALU_AND;
            imm_sel_o  = ImmNone;
            rd_o       = 5'd0;
            regwrite_o = 1'b0;
            memread_o  = 1'b0;
            memwrite_o = 1'b0;
            uses_rs_o  = 1'b0;
            uses_rt_o  = 1'b0;
            wload_o    = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, EX/MEM forwarding, load-use stall and the registered ALU operand slot.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter logic [5:0] ANN_OPCODE = OP_ANN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic [31:0] ex_y,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [31:0] mem_data,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] C,
    output logic [2:0]  ALUSRC,
    output logic [4:0]  out_rd,
    output logic        out_regwrite,
    output logic        out_memread,
    output logic        out_memwrite,
    output logic        out_illegal
);

    logic [2:0] dec_alusrc;
    imm_sel_e   dec_imm_sel;
    logic [4:0] dec_rd;
    logic       dec_regwrite, dec_memread, dec_memwrite;
    logic       dec_uses_rs, dec_uses_rt, dec_wload, dec_illegal;

    alu_decode #(
        .ANN_OPCODE(ANN_OPCODE)
    ) u_decode (
        .instr_i   (in_instr),
        .alusrc_o  (dec_alusrc),
        .imm_sel_o (dec_imm_sel),
        .rd_o      (dec_rd),
        .regwrite_o(dec_regwrite),
        .memread_o (dec_memread),
        .memwrite_o(dec_memwrite),
        .uses_rs_o (dec_uses_rs),
        .uses_rt_o (dec_uses_rt),
        .wload_o   (dec_wload),
        .illegal_o (dec_illegal)
    );

    logic        valid_q, regwrite_q, memread_q, memwrite_q, illegal_q;
    logic [31:0] a_q, b_q, c_q;
    logic [2:0]  alusrc_q;
    logic [4:0]  rd_q;

    logic [4:0]  rs_idx, rt_idx;
    logic [31:0] rs_fwd, rt_fwd, a_d, b_d, c_d;
    logic        ex_fwd_ok, hazard, transfer;

    assign rs_idx = in_instr[25:21];
    assign rt_idx = in_instr[20:16];

    // A held load has no result in EX yet; it can only be forwarded once it reaches MEM.
    assign ex_fwd_ok = valid_q && regwrite_q && !memread_q;

    always_comb begin
        rs_fwd = in_rs_val;
        if (rs_idx != 5'd0 && ex_fwd_ok && rd_q == rs_idx) begin
            rs_fwd = ex_y;
        end else if (rs_idx != 5'd0 && mem_regwrite && mem_rd == rs_idx) begin
            rs_fwd = mem_data;
        end
        rt_fwd = in_rt_val;
        if (rt_idx != 5'd0 && ex_fwd_ok && rd_q == rt_idx) begin
            rt_fwd = ex_y;
        end else if (rt_idx != 5'd0 && mem_regwrite && mem_rd == rt_idx) begin
            rt_fwd = mem_data;
        end
    end

    always_comb begin
        a_d = rs_fwd;
        unique case (dec_imm_sel)
            ImmSext: b_d = {{16{in_instr[15]}}, in_instr[15:0]};
            ImmZext: b_d = {16'd0, in_instr[15:0]};
            default: b_d = rt_fwd;
        endcase
        c_d = dec_wload ? in_rt_val : 32'd0;
    end

    assign hazard = in_valid && valid_q && memread_q && rd_q != 5'd0 &&
                    ((dec_uses_rs && rs_idx == rd_q) || (dec_uses_rt && rt_idx == rd_q));
    assign in_ready = !rst && !flush && !hazard && (!valid_q || out_ready);
    assign transfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q    <= 1'b0;
            alusrc_q   <= ALU_ADD;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            if (rst) begin
                a_q  <= 32'd0;
                b_q  <= 32'd0;
                c_q  <= 32'd0;
                rd_q <= 5'd0;
            end
        end else if (transfer) begin
            valid_q    <= 1'b1;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            alusrc_q   <= dec_alusrc;
            rd_q       <= dec_rd;
            regwrite_q <= dec_regwrite;
            memread_q  <= dec_memread;
            memwrite_q <= dec_memwrite;
            illegal_q  <= dec_illegal;
        end else if (out_ready) begin
            valid_q    <= 1'b0;
            alusrc_q   <= ALU_ADD;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign A            = a_q;
    assign B            = b_q;
    assign C            = c_q;
    assign ALUSRC       = alusrc_q;
    assign out_rd       = rd_q;
    assign out_regwrite = regwrite_q;
    assign out_memread  = memread_q;
    assign out_memwrite = memwrite_q;
    assign out_illegal  = illegal_q;

endmodule
